muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared RV32M opcode constants, FSM encoding and operand-signedness decode
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result handshake bundle between the pipeline and the mul/div unit.
interface muldiv_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on magnitudes,
// followed by a single sign-fix cycle. Divide-by-zero and overflow skip straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb_q;
  logic [5:0]        cnt;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   res_q;

  logic            accept, neg_a, neg_b, div_zero, div_ovf, bypass;
  logic [XLEN-1:0] mag_a, mag_b, bypass_res;

  assign accept   = (state == IDLE) && in_valid && !flush;
  assign neg_a    = a_is_signed(funct3) && a[XLEN-1];
  assign neg_b    = b_is_signed(funct3) && b[XLEN-1];
  assign mag_a    = neg_a ? (~a + 1'b1) : a;
  assign mag_b    = neg_b ? (~b + 1'b1) : b;
  assign div_zero = funct3[2] && (b == '0);
  assign div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) && (a == INT_MIN) && (b == '1);
  assign bypass   = div_zero || div_ovf;

  // funct3[1] separates REM* from DIV* within the divide group.
  always_comb begin
    bypass_res = '0;
    if (div_zero)
      bypass_res = funct3[1] ? a : '1;
    else if (div_ovf)
      bypass_res = funct3[1] ? '0 : INT_MIN;
  end

  logic [XLEN:0]     mul_sum, div_t;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
  assign div_t    = acc[2*XLEN-1:XLEN-1];
  assign div_ge   = div_t >= {1'b0, opb_q};
  assign div_diff = div_t[XLEN-1:0] - opb_q;
  assign prod     = neg_q ? (~acc + 1'b1) : acc;
  assign quo      = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
  assign rem      = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = rem;
    case (op_q)
      F_MUL:                     fix_res = prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             fix_res = quo;
      default:                   fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Flush overrides every other transition, including acceptance and consumption.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bypass ? DONE : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Multiply keeps the multiplier in acc's low half and shifts right;
  // divide keeps remainder:dividend in acc and shifts left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      acc   <= '0;
      opb_q <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= funct3;
          acc   <= {{XLEN{1'b0}}, mag_a};
          opb_q <= mag_b;
          cnt   <= '0;
          neg_q <= neg_a ^ neg_b;
          neg_r <= neg_a;
          res_q <= bypass_res;
        end
        CALC: begin
          if (op_q[2])
            acc <= {div_ge ? div_diff : div_t[XLEN-1:0], acc[XLEN-2:0], div_ge};
          else
            acc <= {mul_sum, acc[XLEN-1:1]};
          cnt <= cnt + 6'd1;
        end
        FIX:     res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = (state == DONE) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M results, latency,
// back-pressure, flush and asynchronous reset behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .funct3    (bus.funct3),
    .a         (bus.a),
    .b         (bus.b),
    .flush     (bus.flush),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .result    (bus.result),
    .busy      (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, scrambles the operand bus after acceptance, then waits
  // for out_valid counting edges from the accepting edge (inclusive).
  task automatic apply_stimulus(input string tag, input logic [2:0] f,
                                input logic [31:0] av, input logic [31:0] bv,
                                input int exp_lat, input logic [31:0] exp_res);
    int edges;
    check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.funct3   = f;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    edges = 1;
    while (!bus.out_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check_output({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check_output({tag, "_result"}, bus.result, exp_res);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_output({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check_output({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic        seen_valid;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = F_MUL;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check_output("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_busy",      32'(bus.busy),      32'd0);
    check_output("rst_result",    bus.result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    apply_stimulus("mul", F_MUL, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
    consume("mul");
    apply_stimulus("mulh", F_MULH, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000);
    consume("mulh");
    apply_stimulus("mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
    consume("mulhu");
    apply_stimulus("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF);
    consume("mulhsu");
    apply_stimulus("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
    consume("div");
    apply_stimulus("rem", F_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
    consume("rem");
    apply_stimulus("divu_zero", F_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    consume("divu_zero");
    apply_stimulus("remu_zero", F_REMU, 32'd5, 32'd0, 1, 32'd5);
    consume("remu_zero");
    apply_stimulus("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    consume("div_ovf");
    apply_stimulus("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    consume("rem_ovf");

    // Back-pressure: result must hold while a competing request is presented.
    apply_stimulus("hold", F_DIVU, 32'd1000, 32'd7, 34, 32'd142);
    held = bus.result;
    bus.in_valid = 1'b1;
    bus.funct3   = F_MUL;
    bus.a        = 32'd3;
    bus.b        = 32'd3;
    repeat (5) begin
      @(posedge clk); #1;
      check_output("hold_result",   bus.result,         held);
      check_output("hold_in_ready", 32'(bus.in_ready),  32'd0);
      check_output("hold_valid",    32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_output("done_no_accept_busy", 32'(bus.busy), 32'd0);
    check_output("done_no_accept_ready", 32'(bus.in_ready), 32'd1);

    // Flush at CALC cycle 10.
    bus.in_valid = 1'b1;
    bus.funct3   = F_MUL;
    bus.a        = 32'd12345;
    bus.b        = 32'd678;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check_output("pre_flush_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_output("flush_busy",     32'(bus.busy),     32'd0);
    check_output("flush_in_ready", 32'(bus.in_ready), 32'd1);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check_output("flush_no_valid", 32'(seen_valid), 32'd0);
    apply_stimulus("post_flush_rem", F_REM, 32'd100, 32'hFFFF_FFF9, 34, 32'd2);
    consume("post_flush_rem");

    // Asynchronous reset in the middle of a divide.
    bus.in_valid = 1'b1;
    bus.funct3   = F_DIV;
    bus.a        = 32'd999;
    bus.b        = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_output("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check_output("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("arst_busy",      32'(bus.busy),      32'd0);
    check_output("arst_result",    bus.result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_stimulus("post_rst_divu", F_DIVU, 32'd100, 32'd7, 34, 32'd14);
    consume("post_rst_divu");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
